// File: rtl/bram_burst_reader.sv
// Burst read sequencer for scratch BRAM port B with a 2-entry output FIFO.
// Define BRAM_READER_WRAP_EN for circular addressing over NUM_WORDS.
module bram_burst_reader #(
  parameter int B_WIDTH         = 64,
  parameter int B_ADDRESS_WIDTH = 3,
  parameter int NUM_WORDS       = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [B_ADDRESS_WIDTH-1:0] base_addr,
  input  logic [B_ADDRESS_WIDTH:0]   length,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       enb,
  output logic                       web,
  output logic [B_ADDRESS_WIDTH-1:0] addrb,
  input  logic [B_WIDTH-1:0]         doutb,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [B_WIDTH-1:0]         m_data,
  output logic                       m_last
);

  localparam int AW = B_ADDRESS_WIDTH;
  localparam logic [AW+1:0] NW = (AW+2)'(NUM_WORDS);
  localparam logic [AW:0] ONE_C = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] ptr_inc;
  logic [AW:0]   issue_q, issue_d;
  logic [AW:0]   beat_q, beat_d;
  logic          err_q, err_d;
  logic          inflight_q;

  logic [B_WIDTH-1:0] mem_q [2];
  logic               wr_q, rd_q;
  logic [1:0]         cnt_q;

  logic          issue, fire, push, pop;
  logic          bad;
  logic [AW+1:0] base_x, len_x;

  assign base_x = {2'b00, base_addr};
  assign len_x  = {1'b0, length};

`ifdef BRAM_READER_WRAP_EN
  localparam logic [AW-1:0] LAST = AW'(NUM_WORDS - 1);
  assign ptr_inc = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
  assign bad     = (len_x > NW) || (base_x >= NW);
`else
  assign ptr_inc = rd_ptr_q + AW'(1);
  assign bad     = ((base_x + len_x) > NW) || (base_x >= NW);
`endif

  // a read needs a free slot counting the word in the BRAM pipe
  assign issue = (state_q == READ) && (issue_q != '0) &&
                 ((2'(inflight_q) + cnt_q) < 2'd2);

  assign m_valid = (cnt_q != 2'd0) || inflight_q;
  assign fire    = m_valid && m_ready;
  assign pop     = fire && (cnt_q != 2'd0);
  assign push    = inflight_q && !(fire && (cnt_q == 2'd0));

  assign m_data = (cnt_q != 2'd0) ? mem_q[rd_q] :
                  (inflight_q ? doutb : '0);
  assign m_last = m_valid && (beat_q == ONE_C);

  assign enb   = issue;
  assign web   = 1'b0;
  assign addrb = issue ? rd_ptr_q : addr_q;
  assign busy  = (state_q == READ) || (state_q == DRAIN);
  assign done  = (state_q == DONE);
  assign err   = (state_q == DONE) && err_q;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    issue_d  = issue_q;
    beat_d   = beat_q;
    err_d    = err_q;
    if (fire) beat_d = beat_q - ONE_C;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (length == '0) begin
            state_d = DONE;
          end else if (bad) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d  = READ;
            rd_ptr_d = base_addr;
            issue_d  = length;
            beat_d   = length;
          end
        end
      end
      READ: begin
        if (issue) begin
          rd_ptr_d = ptr_inc;
          issue_d  = issue_q - ONE_C;
          if (issue_q == ONE_C) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((beat_q == '0) || ((beat_q == ONE_C) && fire))
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      addr_q     <= '0;
      issue_q    <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      issue_q    <= issue_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      inflight_q <= issue;
      if (issue) addr_q <= rd_ptr_q;
      if (push) begin
        mem_q[wr_q] <= doutb;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader: BRAM model, queue-based reference,
// per-cycle compare process, directed and random commands.
module tb_bram_burst_reader;

  localparam int DW = 64;
  localparam int AW = 3;
  localparam int NW = 5;
  localparam logic [DW-1:0] PAT = 64'hA5A5_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, err, enb, web;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb = '0;
  logic          m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;

  logic [DW-1:0] bram [8];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  bram_burst_reader #(
    .B_WIDTH(DW),
    .B_ADDRESS_WIDTH(AW),
    .NUM_WORDS(NW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .err(err),
    .enb(enb),
    .web(web),
    .addrb(addrb),
    .doutb(doutb),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (enb) doutb <= bram[addrb];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, a, e, cyc);
    end
  endtask

  // reference model state
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] adr_q[$];
  logic [DW-1:0] got_q[$];
  bit            act = 0;
  bit            exp_err = 0;
  int            st_c = -10;
  int            done_c = -10;
  int            n_iss = 0;
  int            n_take = 0;
  bit            p_valid = 0;
  bit            p_ready = 0;
  logic [DW-1:0] p_data = '0;
  logic [AW-1:0] last_adr = '0;
  bit            full_rate = 0;
  bit            saw_enb = 0;
  bit            saw_valid = 0;
  bit            idle_m, exp_done, mbad;
  int            mb, ml, ma;

  always @(negedge clk) begin
    if (!rst_n) begin
      act = 0;
      exp_q.delete();
      adr_q.delete();
      done_c = -10;
      p_valid = 0;
      last_adr = '0;
    end else begin
      idle_m   = !act && (cyc != done_c);
      exp_done = (cyc == done_c);
      chk("done", done, exp_done);
      chk("err", err, exp_done && exp_err);
      chk("busy", busy, act && (cyc > st_c));
      chk("web", web, 0);
      if (enb) saw_enb = 1;
      if (m_valid) saw_valid = 1;
      if (act && cyc == st_c + 1) chk("first_read", enb, 1);
      if (act && cyc == st_c + 2) chk("first_valid", m_valid, 1);
      if (!(act && adr_q.size() > 0)) begin
        chk("enb_quiet", enb, 0);
      end else if (enb) begin
        chk("addrb", addrb, adr_q[0]);
        last_adr = adr_q.pop_front();
        n_iss++;
        chk("outstanding_le2", (n_iss - n_take) <= 2, 1);
      end
      if (!enb) chk("addrb_hold", addrb, last_adr);
      if (p_valid && !p_ready) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, p_data);
      end
      if (m_valid) begin
        if (!act || exp_q.size() == 0) begin
          chk("valid_spurious", m_valid, 0);
        end else begin
          chk("data", m_data, exp_q[0]);
          chk("last", m_last, exp_q.size() == 1);
          if (m_ready) begin
            if (full_rate) chk("beat_cycle", cyc, st_c + 2 + n_take);
            got_q.push_back(m_data);
            void'(exp_q.pop_front());
            n_take++;
            if (exp_q.size() == 0) begin
              act = 0;
              done_c = cyc + 1;
              exp_err = 0;
            end
          end
        end
      end
      if (start && idle_m) begin
        mb = int'(base_addr);
        ml = int'(length);
`ifdef BRAM_READER_WRAP_EN
        mbad = (ml > NW) || (mb >= NW);
`else
        mbad = (mb + ml > NW) || (mb >= NW);
`endif
        if (ml == 0) begin
          done_c = cyc + 1;
          exp_err = 0;
        end else if (mbad) begin
          done_c = cyc + 1;
          exp_err = 1;
        end else begin
          act = 1;
          st_c = cyc;
          n_iss = 0;
          n_take = 0;
          for (int k = 0; k < ml; k++) begin
            ma = (mb + k) % NW;
            adr_q.push_back(AW'(ma));
            exp_q.push_back(bram[ma]);
          end
        end
      end
      p_valid = m_valid;
      p_ready = m_ready;
      p_data  = m_data;
    end
  end

  function automatic bit rdy(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k < 2) || ((k - 2) % 3 == 0);
    return $urandom_range(0, 2) != 0;
  endfunction

  task automatic cmd(input int b, input int l, input int mode,
                     input bit poke, output int dk, output bit e_seen);
    bit fin = 0;
    dk = -1;
    e_seen = 0;
    got_q.delete();
    saw_enb = 0;
    saw_valid = 0;
    full_rate = (mode == 0);
    for (int k = 0; k < 200 && !fin; k++) begin
      start = (k == 0) || (poke && k == 2);
      if (k == 0) begin
        base_addr = AW'(b);
        length = (AW+1)'(l);
      end else if (start) begin
        base_addr = AW'($urandom);
        length = (AW+1)'($urandom_range(1, 3));
      end
      m_ready = rdy(mode, k);
      @(negedge clk);
      if (done) begin
        fin = 1;
        dk = k;
        e_seen = err;
      end
      @(posedge clk);
      #1;
    end
    start = 0;
    if (!fin) chk("timeout_done", 0, 1);
  endtask

  int  dk;
  bit  es;

  initial begin
    for (int i = 0; i < 8; i++)
      bram[i] = (i < NW) ? (PAT | DW'(i)) : DW'({$urandom, $urandom});
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_enb", enb, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    cmd(0, 5, 0, 0, dk, es);
    chk("t1_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      chk("t1_beat", got_q[i], PAT + DW'(i));
    chk("t1_done_k", dk, 7);
    chk("t1_err", es, 0);

    cmd(1, 3, 1, 1, dk, es);
    chk("t2_count", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      chk("t2_beat", got_q[i], PAT + DW'(i + 1));
    chk("t2_done_k", dk, 9);

    cmd(2, 0, 0, 0, dk, es);
    chk("t3_done_k", dk, 1);
    chk("t3_err", es, 0);
    chk("t3_enb", saw_enb, 0);
    chk("t3_valid", saw_valid, 0);

    cmd(3, 4, 0, 0, dk, es);
`ifdef BRAM_READER_WRAP_EN
    chk("t4_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk("t4_beat", got_q[i], PAT + DW'((i + 3) % NW));
    chk("t4_err", es, 0);
`else
    chk("t4_done_k", dk, 1);
    chk("t4_err", es, 1);
    chk("t4_enb", saw_enb, 0);
    chk("t4_valid", saw_valid, 0);
`endif

    // reset while second beat is stalled
    full_rate = 0;
    start = 1;
    base_addr = '0;
    length = 4'd5;
    m_ready = 1;
    @(posedge clk);
    #1;
    start = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    m_ready = 0;
    @(posedge clk);
    #1;
    chk("t5_stalled_valid", m_valid, 1);
    chk("t5_stalled_data", m_data, PAT + DW'(1));
    #2;
    rst_n = 0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_err", err, 0);
    chk("t5_enb", enb, 0);
    chk("t5_addrb", addrb, 0);
    chk("t5_valid", m_valid, 0);
    chk("t5_data", m_data, 0);
    chk("t5_last", m_last, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    cmd(0, 1, 0, 0, dk, es);
    chk("t5_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("t5_beat", got_q[0], PAT);
    chk("t5_done_k", dk, 3);

    for (int n = 0; n < 40; n++) begin
      int b, l;
      b = ($urandom_range(0, 3) != 0) ? $urandom_range(0, NW - 1)
                                      : $urandom_range(0, 7);
      l = $urandom_range(0, 9);
      cmd(b, l, 2, $urandom_range(0, 1) == 1, dk, es);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
